// File: rtl/timer_device_pkg.sv
// Shared definitions for the memory-mapped down-counter timers: FSM encoding,
// register offsets, CTRL layout and the device base addresses used by the bridge.
package timer_device_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam logic [31:0] TIMER0_BASE = 32'h0000_7F00;
  localparam logic [31:0] TIMER1_BASE = 32'h0000_7F10;

  // Field order matches the CTRL bit indices above: {IM, MODE[1:0], EN}.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_word(input ctrl_t c);
    return {28'b0, c};
  endfunction

endpackage

// File: rtl/timer_device.sv
// Programmable 32-bit down-counter peripheral with CTRL/PRESET/COUNT registers,
// one-shot or auto-reload operation and a maskable interrupt request.
module timer_device
  import timer_device_pkg::*;
#(
  parameter logic [31:0] RESET_PRESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  state_t      state, state_next;
  ctrl_t       ctrl, ctrl_next;
  logic [31:0] preset, preset_next;
  logic [31:0] count, count_next;
  logic        irq_flag, irq_flag_next;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_next    = state;
    ctrl_next     = ctrl;
    preset_next   = preset;
    count_next    = count;
    irq_flag_next = irq_flag;

    unique case (state)
      ST_IDLE: begin
        if (ctrl.en) begin
          state_next    = ST_LOAD;
          irq_flag_next = 1'b0;
        end
      end
      ST_LOAD: begin
        count_next = preset;
        state_next = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl.en) begin
          state_next = ST_IDLE;
        end else if (count > 32'd1) begin
          count_next = count - 32'd1;
        end else begin
          count_next    = 32'd0;
          irq_flag_next = 1'b1;
          state_next    = ST_INT;
        end
      end
      ST_INT: begin
        state_next = ST_IDLE;
        if (ctrl.mode == MODE_RELOAD) irq_flag_next = 1'b0;
        else                          ctrl_next.en  = 1'b0;
      end
      default: state_next = ST_IDLE;
    endcase

    // Bus writes are applied last so a CPU CTRL write overrides the FSM's EN clear.
    if (we) begin
      unique case (addr)
        ADDR_CTRL: begin
          ctrl_next     = ctrl_t'(din[3:0]);
          irq_flag_next = 1'b0;
        end
        ADDR_PRESET: preset_next = din;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ctrl     <= '0;
      preset   <= RESET_PRESET;
      count    <= 32'd0;
      irq_flag <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      state    <= state_next;
      ctrl     <= ctrl_next;
      preset   <= preset_next;
      count    <= count_next;
      irq_flag <= irq_flag_next;
    end
  end

  always_comb begin
    dout = 32'd0;
    unique case (addr)
      ADDR_CTRL:   dout = ctrl_word(ctrl);
      ADDR_PRESET: dout = preset;
      ADDR_COUNT:  dout = count;
      default:     dout = 32'd0;
    endcase
  end

  assign irq = ctrl.im & irq_flag;

endmodule

// File: tb/tb_timer_device.sv
// Self-checking bench for timer_device: directed scenarios followed by random
// bus traffic, all checked against a timeline-based reference model.
module tb_timer_device;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic        irq;

  int total = 0;
  int bad   = 0;

  timer_device #(.RESET_PRESET(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Reference model: a run is described by the edge it loaded on and the
  // preset it latched; COUNT is derived arithmetically from elapsed edges.
  typedef enum {M_OFF, M_ARMED, M_RUN, M_DONE} mphase_t;
  mphase_t     phase;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count, run_preset;
  logic        m_flag;
  longint      edge_no, load_edge;

  task automatic model_reset();
    phase      = M_OFF;
    m_ctrl     = 4'd0;
    m_preset   = 32'd0;
    m_count    = 32'd0;
    run_preset = 32'd0;
    m_flag     = 1'b0;
    load_edge  = 0;
  endtask

  task automatic model_edge(input logic w, input logic [1:0] a, input logic [31:0] d);
    logic   en, reload;
    longint span, elapsed;
    en     = m_ctrl[0];
    reload = (m_ctrl[2:1] == 2'b01);
    edge_no++;
    case (phase)
      M_OFF: if (en) begin
        phase  = M_ARMED;
        m_flag = 1'b0;
      end
      M_ARMED: begin
        run_preset = m_preset;
        load_edge  = edge_no;
        m_count    = m_preset;
        phase      = M_RUN;
      end
      M_RUN: begin
        if (!en) begin
          phase = M_OFF;
        end else begin
          elapsed = edge_no - load_edge;
          span    = (run_preset == 32'd0) ? 64'sd1 : longint'(run_preset);
          if (elapsed >= span) begin
            m_count = 32'd0;
            m_flag  = 1'b1;
            phase   = M_DONE;
          end else begin
            m_count = run_preset - 32'(elapsed);
          end
        end
      end
      M_DONE: begin
        if (reload) m_flag = 1'b0;
        else        m_ctrl[0] = 1'b0;
        phase = M_OFF;
      end
      default: phase = M_OFF;
    endcase
    if (w && a == 2'd0) begin
      m_ctrl = d[3:0];
      m_flag = 1'b0;
    end else if (w && a == 2'd1) begin
      m_preset = d;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = dout;
  endtask

  task automatic expect_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check(tag, v, exp);
  endtask

  task automatic check_model(input string tag);
    logic [31:0] v;
    rd(2'd0, v); check({tag, ":ctrl"},   v, {28'd0, m_ctrl});
    rd(2'd1, v); check({tag, ":preset"}, v, m_preset);
    rd(2'd2, v); check({tag, ":count"},  v, m_count);
    rd(2'd3, v); check({tag, ":unused"}, v, 32'd0);
    check({tag, ":irq"}, {31'd0, irq}, {31'd0, m_ctrl[3] & m_flag});
  endtask

  task automatic cycle(input logic w = 1'b0, input logic [1:0] a = 2'd0,
                       input logic [31:0] d = 32'd0, input string tag = "cyc");
    we   = w;
    addr = a;
    din  = d;
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge(w, a, d);
    #1;
    we  = 1'b0;
    din = 32'd0;
    check_model(tag);
  endtask

  initial begin
    int          seq [5] = '{2, 1, 0, 0, 0};
    int          pulses;
    int          r;
    logic [1:0]  ra;
    logic [31:0] rdat;

    edge_no = 0;
    model_reset();

    // Power-on reset
    cycle(.tag("rst"));
    cycle(.tag("rst"));
    reset = 1'b0;
    expect_reg("rst_ctrl", 2'd0, 32'd0);
    expect_reg("rst_count", 2'd2, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);

    // Reset asserted mid-count aborts asynchronously
    cycle(1'b1, 2'd1, 32'd100, "midrst");
    cycle(1'b1, 2'd0, 32'h9, "midrst");
    repeat (10) cycle(.tag("midrst"));
    expect_reg("midrst_running", 2'd2, 32'd92);
    reset = 1'b1;
    model_reset();
    #1;
    expect_reg("midrst_ctrl", 2'd0, 32'd0);
    expect_reg("midrst_preset", 2'd1, 32'd0);
    expect_reg("midrst_count", 2'd2, 32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    cycle(.tag("midrst_hold"));
    reset = 1'b0;
    cycle(.tag("midrst_rel"));

    // One-shot, PRESET=3
    cycle(1'b1, 2'd1, 32'd3, "os");
    cycle(1'b1, 2'd0, 32'h9, "os_e0");
    cycle(.tag("os_e1"));
    cycle(.tag("os_e2")); expect_reg("os_e2_count", 2'd2, 32'd3);
    cycle(.tag("os_e3")); expect_reg("os_e3_count", 2'd2, 32'd2);
    cycle(.tag("os_e4")); expect_reg("os_e4_count", 2'd2, 32'd1);
    check("os_e4_irq", {31'd0, irq}, 32'd0);
    cycle(.tag("os_e5")); expect_reg("os_e5_count", 2'd2, 32'd0);
    check("os_e5_irq", {31'd0, irq}, 32'd1);
    cycle(.tag("os_e6")); expect_reg("os_e6_ctrl", 2'd0, 32'h8);
    check("os_e6_irq", {31'd0, irq}, 32'd1);
    repeat (3) cycle(.tag("os_hold"));
    check("os_hold_irq", {31'd0, irq}, 32'd1);
    cycle(1'b1, 2'd0, 32'h8, "os_ack");
    check("os_ack_irq", {31'd0, irq}, 32'd0);

    // Auto-reload, PRESET=2: one-cycle pulse every 5 cycles
    cycle(1'b1, 2'd1, 32'd2, "ar");
    cycle(1'b1, 2'd0, 32'hB, "ar_e0");
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      cycle(.tag("ar"));
      if (irq) pulses++;
      check($sformatf("ar_irq_e%0d", k), {31'd0, irq},
            {31'd0, (k >= 4) && ((k - 4) % 5 == 0)});
      if (k >= 2) expect_reg($sformatf("ar_count_e%0d", k), 2'd2, 32'(seq[(k - 2) % 5]));
    end
    check("ar_pulses", 32'(pulses), 32'd3);
    cycle(1'b1, 2'd0, 32'h0, "ar_stop");
    repeat (2) cycle(.tag("ar_stop"));

    // Masked expiry: irq never asserts, EN self-clears
    cycle(1'b1, 2'd1, 32'd1, "mask");
    cycle(1'b1, 2'd0, 32'h1, "mask_e0");
    pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      cycle(.tag("mask"));
      if (irq) pulses++;
    end
    check("mask_irq_seen", 32'(pulses), 32'd0);
    expect_reg("mask_ctrl", 2'd0, 32'h0);

    // PRESET=0 expires on the first count cycle
    cycle(1'b1, 2'd1, 32'd0, "p0");
    cycle(1'b1, 2'd0, 32'h9, "p0_e0");
    for (int k = 1; k <= 3; k++) begin
      cycle(.tag("p0"));
      check($sformatf("p0_irq_e%0d", k), {31'd0, irq}, {31'd0, k == 3});
    end
    cycle(1'b1, 2'd0, 32'h8, "p0_ack");

    // PRESET rewritten mid-count only applies at the next load
    cycle(1'b1, 2'd1, 32'd10, "pmid");
    cycle(1'b1, 2'd0, 32'h1, "pmid_e0");
    cycle(.tag("pmid_e1"));
    cycle(.tag("pmid_e2")); expect_reg("pmid_e2_count", 2'd2, 32'd10);
    cycle(1'b1, 2'd1, 32'd5, "pmid_e3");
    cycle(.tag("pmid_e4")); expect_reg("pmid_e4_count", 2'd2, 32'd8);
    expect_reg("pmid_preset", 2'd1, 32'd5);
    cycle(1'b1, 2'd0, 32'h0, "pmid_stop");
    cycle(.tag("pmid_idle"));
    cycle(1'b1, 2'd0, 32'h1, "pmid2_e0");
    cycle(.tag("pmid2_e1"));
    cycle(.tag("pmid2_e2")); expect_reg("pmid2_e2_count", 2'd2, 32'd5);
    cycle(1'b1, 2'd0, 32'h0, "pmid2_stop");
    cycle(.tag("pmid2_idle"));

    // Bus decode: COUNT and offset 3 are read-only, CTRL keeps 4 bits
    cycle(1'b1, 2'd2, 32'hDEAD, "dec_w2");
    expect_reg("dec_count_w2", 2'd2, 32'd4);
    cycle(1'b1, 2'd3, 32'hDEAD, "dec_w3");
    expect_reg("dec_count_w3", 2'd2, 32'd4);
    expect_reg("dec_off3", 2'd3, 32'd0);
    cycle(1'b1, 2'd0, 32'hFFFF_FFFF, "dec_ctrl");
    expect_reg("dec_ctrl_rb", 2'd0, 32'h0000_000F);
    cycle(1'b1, 2'd0, 32'h0, "dec_stop");

    // Random bus traffic against the model
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        reset = 1'b1;
        model_reset();
        #1;
        check_model("rnd_rst");
        cycle(.tag("rnd_rst_hold"));
        reset = 1'b0;
      end else if (r < 30) begin
        ra   = 2'($urandom_range(0, 3));
        rdat = (ra == 2'd1) ? 32'($urandom_range(0, 6)) : 32'($urandom);
        cycle(1'b1, ra, rdat, "rnd_w");
      end else begin
        cycle(1'b0, 2'($urandom_range(0, 3)), 32'($urandom), "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
